// File: rtl/execute_pipe.sv
// Execute stage: single-cycle ALU with a valid/ready handshake on both sides, plus an
// optional shift-add multiplier enabled by defining EXECUTE_PIPE_MULT_EN.
module execute_pipe #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     read_data_1,
   input  logic [DATA_W-1:0]     read_data_2,
   input  logic [DATA_W-1:0]     imm,
   input  logic [DATA_W-1:0]     next_pc,
   input  logic [1:0]            alu_op,
   input  logic                  alu_src,
   input  logic                  reg_dest,
   input  logic [REG_ADDR_W-1:0] rt,
   input  logic [REG_ADDR_W-1:0] rd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     alu_result,
   output logic [DATA_W-1:0]     branch_target,
   output logic                  zero,
   output logic [REG_ADDR_W-1:0] write_register,
   output logic                  busy
);

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   logic [DATA_W-1:0]     op_b;
   logic [5:0]            funct;
   logic [DATA_W-1:0]     alu_result_d;
   logic [DATA_W-1:0]     branch_target_d;
   logic                  zero_d;
   logic [REG_ADDR_W-1:0] write_register_d;
   logic                  slt_d;
   logic                  fire_in;
   logic                  fire_out;
   logic                  is_mult;
   logic                  busy_w;

   logic                  out_valid_q;
   logic [DATA_W-1:0]     alu_result_q;
   logic [DATA_W-1:0]     branch_target_q;
   logic                  zero_q;
   logic [REG_ADDR_W-1:0] write_register_q;

   assign op_b             = alu_src ? imm : read_data_2;
   assign funct            = imm[5:0];
   assign slt_d            = $signed(read_data_1) < $signed(op_b);
   assign branch_target_d  = next_pc + {imm[DATA_W-3:0], 2'b00};
   assign zero_d           = (read_data_1 == read_data_2);
   assign write_register_d = reg_dest ? rd : rt;

   always_comb begin
      alu_result_d = '0;
      case (alu_op)
         2'b00: alu_result_d = read_data_1 + op_b;
         2'b01: alu_result_d = read_data_1 - op_b;
         2'b10: begin
            case (funct)
               F_ADD:   alu_result_d = read_data_1 + op_b;
               F_SUB:   alu_result_d = read_data_1 - op_b;
               F_AND:   alu_result_d = read_data_1 & op_b;
               F_OR:    alu_result_d = read_data_1 | op_b;
               F_SLT:   alu_result_d = {{(DATA_W-1){1'b0}}, slt_d};
               default: alu_result_d = '0;
            endcase
         end
         default: alu_result_d = '0;
      endcase
   end

`ifdef EXECUTE_PIPE_MULT_EN
   localparam logic [5:0] F_MULT = 6'b011000;
   localparam int         CNT_W  = $clog2(DATA_W);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t                state_q;
   logic [DATA_W-1:0]     mcand_q;
   logic [DATA_W-1:0]     mplier_q;
   logic [DATA_W-1:0]     acc_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_W-1:0]     pend_bt_q;
   logic                  pend_zero_q;
   logic [REG_ADDR_W-1:0] pend_wr_q;

   assign is_mult = (alu_op == 2'b10) && (funct == F_MULT);
   assign busy_w  = (state_q != S_IDLE);
`else
   assign is_mult = 1'b0;
   assign busy_w  = 1'b0;
`endif

   assign in_ready = !reset && !busy_w && (!out_valid_q || out_ready);
   assign fire_in  = in_valid && in_ready;
   assign fire_out = out_valid_q && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q      <= 1'b0;
         alu_result_q     <= '0;
         branch_target_q  <= '0;
         zero_q           <= 1'b0;
         write_register_q <= '0;
`ifdef EXECUTE_PIPE_MULT_EN
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         pend_bt_q   <= '0;
         pend_zero_q <= 1'b0;
         pend_wr_q   <= '0;
`endif
      end else begin
         if (fire_out) out_valid_q <= 1'b0;
         if (fire_in && !is_mult) begin
            out_valid_q      <= 1'b1;
            alu_result_q     <= alu_result_d;
            branch_target_q  <= branch_target_d;
            zero_q           <= zero_d;
            write_register_q <= write_register_d;
         end
`ifdef EXECUTE_PIPE_MULT_EN
         case (state_q)
            S_IDLE: begin
               // Side results are parked until the product is ready, so the visible outputs stay put.
               if (fire_in && is_mult) begin
                  mcand_q     <= read_data_1;
                  mplier_q    <= op_b;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  pend_bt_q   <= branch_target_d;
                  pend_zero_q <= zero_d;
                  pend_wr_q   <= write_register_d;
                  state_q     <= S_MUL;
               end
            end
            S_MUL: begin
               if (mplier_q[0]) acc_q <= acc_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= S_DONE;
            end
            S_DONE: begin
               if (!out_valid_q || out_ready) begin
                  out_valid_q      <= 1'b1;
                  alu_result_q     <= acc_q;
                  branch_target_q  <= pend_bt_q;
                  zero_q           <= pend_zero_q;
                  write_register_q <= pend_wr_q;
                  state_q          <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
`endif
      end
   end

   assign out_valid      = out_valid_q;
   assign alu_result     = alu_result_q;
   assign branch_target  = branch_target_q;
   assign zero           = zero_q;
   assign write_register = write_register_q;
   assign busy           = busy_w;

endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench for execute_pipe: results are predicted at transfer in and compared at transfer out.
module tb_execute_pipe;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] bt;
      logic        z;
      logic [4:0]  wr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] read_data_1, read_data_2, imm, next_pc;
   logic [1:0]  alu_op;
   logic        alu_src, reg_dest;
   logic [4:0]  rt, rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_result, branch_target;
   logic        zero;
   logic [4:0]  write_register;
   logic        busy;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   execute_pipe #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .read_data_1(read_data_1), .read_data_2(read_data_2), .imm(imm), .next_pc(next_pc),
      .alu_op(alu_op), .alu_src(alu_src), .reg_dest(reg_dest), .rt(rt), .rd(rd),
      .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
      .branch_target(branch_target), .zero(zero), .write_register(write_register), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b2,
                                  input logic [31:0] im, input logic [31:0] npc, input logic src,
                                  input logic rdst, input logic [4:0] rt_v, input logic [4:0] rd_v);
      exp_t        e;
      logic [31:0] b;
      logic [63:0] prod;
      b    = src ? im : b2;
      prod = {32'd0, a} * {32'd0, b};
      e.bt = npc + im * 32'd4;
      e.z  = (a == b2);
      e.wr = rdst ? rd_v : rt_v;
      e.res = 32'd0;
      if (op == 2'b00) e.res = a + b;
      else if (op == 2'b01) e.res = a + ~b + 32'd1;
      else if (op == 2'b10) begin
         if (im[5:0] == 6'h20) e.res = a + b;
         else if (im[5:0] == 6'h22) e.res = a + ~b + 32'd1;
         else if (im[5:0] == 6'h24) e.res = a & b;
         else if (im[5:0] == 6'h25) e.res = a | b;
         else if (im[5:0] == 6'h2A)
            e.res = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
`ifdef EXECUTE_PIPE_MULT_EN
         else if (im[5:0] == 6'h18) e.res = prod[31:0];
`endif
      end
      return e;
   endfunction

   // Drive one op; it stays presented until accepted or the bound expires.
   task automatic send_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [31:0] npc, input logic src,
                          input logic rdst, input logic [4:0] rt_v, input logic [4:0] rd_v,
                          input bit rnd_rdy);
      int waited = 0;
      alu_op = op; read_data_1 = a; read_data_2 = b; imm = im; next_pc = npc;
      alu_src = src; reg_dest = rdst; rt = rt_v; rd = rd_v; in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         if (waited >= 200) begin
            chk("send_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
         end
         waited++;
         @(posedge clk); #1;
         if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      end
      sb.push_back(model(op, a, b, im, npc, src, rdst, rt_v, rd_v));
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_extra_output", 64'd1, 64'd0);
         else begin
            mon_e = sb.pop_front();
            $display("out: res=0x%08h bt=0x%08h z=%0b wr=%0d", alu_result, branch_target, zero, write_register);
            chk("sb_res", 64'(alu_result), 64'(mon_e.res));
            chk("sb_bt",  64'(branch_target), 64'(mon_e.bt));
            chk("sb_zero", 64'(zero), 64'(mon_e.z));
            chk("sb_wr",  64'(write_register), 64'(mon_e.wr));
         end
      end
   end

   initial begin : main
      int          lat;
      int          t0;
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [5:0]  fn_tab [6];
      fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24;
      fn_tab[3] = 6'h25; fn_tab[4] = 6'h2A; fn_tab[5] = 6'h3F;

      // Reset with an op offered: it must be refused and ignored.
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      read_data_1 = 32'd1; read_data_2 = 32'd2; imm = 32'd0; next_pc = 32'd0;
      alu_op = 2'b00; alu_src = 1'b0; reg_dest = 1'b0; rt = 5'd3; rd = 5'd4;
      repeat (3) begin @(posedge clk); #1; chk("reset_in_ready", 64'(in_ready), 64'd0); end
      reset = 1'b0; in_valid = 1'b0;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_alu_result", 64'(alu_result), 64'd0);
      chk("reset_bt", 64'(branch_target), 64'd0);
      chk("reset_zero", 64'(zero), 64'd0);
      chk("reset_wr", 64'(write_register), 64'd0);
      idle(1);

      // funct add 5+7
      send_op(2'b10, 32'd5, 32'd7, 32'h20, 32'h40, 1'b0, 1'b1, 5'd1, 5'd9, 1'b0);
      in_valid = 1'b0;
      chk("add_out_valid", 64'(out_valid), 64'd1);
      chk("add_res", 64'(alu_result), 64'd12);
      chk("add_zero", 64'(zero), 64'd0);
      chk("add_wr_rd", 64'(write_register), 64'd9);
      idle(1);

      // subtract equal operands, negative immediate branch
      send_op(2'b01, 32'h1234, 32'h1234, 32'hFFFF_FFFF, 32'h100, 1'b0, 1'b0, 5'd7, 5'd2, 1'b0);
      in_valid = 1'b0;
      chk("sub_zero", 64'(zero), 64'd1);
      chk("sub_res", 64'(alu_result), 64'd0);
      chk("sub_bt", 64'(branch_target), 64'hFC);
      chk("sub_wr_rt", 64'(write_register), 64'd7);
      idle(1);

      // signed slt and unknown funct
      send_op(2'b10, 32'hFFFF_FFFF, 32'd1, 32'h2A, 32'h0, 1'b0, 1'b0, 5'd1, 5'd1, 1'b0);
      in_valid = 1'b0;
      chk("slt_res", 64'(alu_result), 64'd1);
      idle(1);
      send_op(2'b10, 32'd9, 32'd3, 32'h3F, 32'h0, 1'b0, 1'b0, 5'd1, 5'd1, 1'b0);
      in_valid = 1'b0;
      wait_valid(lat);
      chk("unknown_latency", 64'(lat), 64'd1);
      chk("unknown_res", 64'(alu_result), 64'd0);
      send_op(2'b11, 32'd9, 32'd3, 32'h20, 32'h0, 1'b0, 1'b0, 5'd1, 5'd1, 1'b0);
      in_valid = 1'b0;
      chk("reserved_res", 64'(alu_result), 64'd0);
      // zero ignores alu_src
      send_op(2'b00, 32'd6, 32'd6, 32'd1, 32'h0, 1'b1, 1'b0, 5'd1, 5'd1, 1'b0);
      in_valid = 1'b0;
      chk("immsrc_res", 64'(alu_result), 64'd7);
      chk("immsrc_zero", 64'(zero), 64'd1);
      idle(1);

      // Back-to-back burst at one op per cycle.
      t0 = cyc;
      for (int i = 0; i < 4; i++)
         send_op(2'b00, 32'(i * 11), 32'd3, 32'd0, 32'(i * 4), 1'b0, 1'b0, 5'(i), 5'd0, 1'b0);
      chk("burst_cycles", 64'(cyc - t0), 64'd4);
      idle(2);

      // Backpressure: result held, new op refused, then both delivered once.
      out_ready = 1'b0;
      send_op(2'b00, 32'd100, 32'd23, 32'd0, 32'd0, 1'b0, 1'b0, 5'd5, 5'd6, 1'b0);
      alu_op = 2'b10; read_data_1 = 32'hF0; read_data_2 = 32'h0F; imm = 32'h25; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_out_valid", 64'(out_valid), 64'd1);
         chk("stall_res", 64'(alu_result), 64'd123);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send_op(2'b10, 32'hF0, 32'h0F, 32'h25, 32'd0, 1'b0, 1'b1, 5'd5, 5'd8, 1'b0);
      in_valid = 1'b0;
      chk("release_res", 64'(alu_result), 64'hFF);
      idle(2);
      chk("release_sb_empty", 64'(sb.size()), 64'd0);

`ifdef EXECUTE_PIPE_MULT_EN
      send_op(2'b10, 32'h0000_FFFF, 32'h0001_0001, 32'h18, 32'h10, 1'b0, 1'b1, 5'd2, 5'd3, 1'b0);
      in_valid = 1'b0;
      chk("mult_busy", 64'(busy), 64'd1);
      wait_valid(lat);
      chk("mult_latency", 64'(lat), 64'd34);
      chk("mult_res", 64'(alu_result), 64'hFFFF_FFFF);
      idle(2);
      // reset at cycle 10 of a mult discards it
      send_op(2'b10, 32'd3, 32'd4, 32'h18, 32'h0, 1'b0, 1'b0, 5'd2, 5'd3, 1'b0);
      repeat (9) begin @(posedge clk); #1; end
      reset = 1'b1;
      chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      sb.delete();
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_res", 64'(alu_result), 64'd0);
      send_op(2'b00, 32'd40, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 5'd1, 5'd1, 1'b0);
      in_valid = 1'b0;
      chk("post_rst_add", 64'(alu_result), 64'd42);
`else
      send_op(2'b10, 32'd3, 32'd4, 32'h18, 32'h0, 1'b0, 1'b0, 5'd2, 5'd3, 1'b0);
      in_valid = 1'b0;
      wait_valid(lat);
      chk("nomult_latency", 64'(lat), 64'd1);
      chk("nomult_res", 64'(alu_result), 64'd0);
      chk("nomult_busy", 64'(busy), 64'd0);
      // reset mid-stream clears a pending result
      send_op(2'b00, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd1, 5'd1, 1'b0);
      out_ready = 1'b0; in_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; out_ready = 1'b1;
      sb.delete();
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_res", 64'(alu_result), 64'd0);
      send_op(2'b00, 32'd40, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 5'd1, 5'd1, 1'b0);
      in_valid = 1'b0;
      chk("post_rst_add", 64'(alu_result), 64'd42);
`endif
      idle(2);

      // Random single-cycle ops under random backpressure.
      for (int i = 0; i < 60; i++) begin
         op = 2'($urandom_range(0, 3));
         fn = fn_tab[$urandom_range(0, 5)];
         send_op(op, $urandom, ($urandom_range(0, 3) == 0) ? 32'h55 : $urandom,
                 {$urandom_range(0, 32'h03FF_FFFF), fn}, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 1'b1);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      out_ready = 1'b1;
      idle(5);
      chk("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
